// File: rtl/pfe_pkg.sv
// Shared types and helpers for the stride prefetch engine.
package pfe_pkg;

    typedef enum logic {
        PFE_IDLE,
        PFE_ISSUE
    } pfe_state_e;

    // Add two values, clamping the result at 2^w-1 (w <= 32).
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/pfe_stride_engine_if.sv
// Op input, per-pipe DC/L2 request channels and stats of the engine.
// master = generator/cache side, slave = the engine itself.
interface pfe_stride_engine_if #(
    parameter int NPIPE    = 2,
    parameter int ADDR_W   = 39,
    parameter int STRIDE_W = 8,
    parameter int CNT_W    = 4,
    parameter int STAT_W   = 16
);
    logic                      pfgtopfe_op_valid;
    logic                      pfgtopfe_op_retry;
    logic [ADDR_W-1:0]         pfgtopfe_op_laddr;
    logic [STRIDE_W-1:0]       pfgtopfe_op_stride;
    logic [CNT_W-1:0]          pfgtopfe_op_count;
    logic                      pfgtopfe_op_l2;
    logic [NPIPE-1:0]          pftodc_req_valid;
    logic [NPIPE-1:0]          pftodc_req_retry;
    logic [NPIPE*ADDR_W-1:0]   pftodc_req_laddr;
    logic [NPIPE-1:0]          pftol2_req_valid;
    logic [NPIPE-1:0]          pftol2_req_retry;
    logic [NPIPE*ADDR_W-1:0]   pftol2_req_laddr;
    logic [NPIPE*STAT_W-1:0]   pf_dcstats_in;
    logic [NPIPE*STAT_W-1:0]   pf_l2stats_in;
    logic [STAT_W-1:0]         pf_dcstats;
    logic [STAT_W-1:0]         pf_l2stats;
    logic [STAT_W-1:0]         pf_issued;
    logic [STAT_W-1:0]         pf_dropped;

    modport slave (
        input  pfgtopfe_op_valid, pfgtopfe_op_laddr,
        input  pfgtopfe_op_stride, pfgtopfe_op_count,
        input  pfgtopfe_op_l2,
        output pfgtopfe_op_retry,
        output pftodc_req_valid, pftodc_req_laddr,
        input  pftodc_req_retry,
        output pftol2_req_valid, pftol2_req_laddr,
        input  pftol2_req_retry,
        input  pf_dcstats_in, pf_l2stats_in,
        output pf_dcstats, pf_l2stats,
        output pf_issued, pf_dropped
    );

    modport master (
        output pfgtopfe_op_valid, pfgtopfe_op_laddr,
        output pfgtopfe_op_stride, pfgtopfe_op_count,
        output pfgtopfe_op_l2,
        input  pfgtopfe_op_retry,
        input  pftodc_req_valid, pftodc_req_laddr,
        output pftodc_req_retry,
        input  pftol2_req_valid, pftol2_req_laddr,
        output pftol2_req_retry,
        output pf_dcstats_in, pf_l2stats_in,
        input  pf_dcstats, pf_l2stats,
        input  pf_issued, pf_dropped
    );

endinterface

// File: rtl/pfe_opq.sv
// Op FIFO for the stride engine; full is a pure state flag.
module pfe_opq
    import pfe_pkg::*;
#(
    parameter int W     = 52,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp_q;
    logic [AW:0]  rp_q;
    logic         do_push;
    logic         do_pop;

    assign full    = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty   = (wp_q == rp_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + (AW+1)'(1);
            if (do_pop)  rp_q <= rp_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pfe_stride_engine.sv
// Stride prefetch engine: queues ops and expands them round-robin.
// PFE_DEDUP_EN drops lines equal to the level's last-issued line.
module pfe_stride_engine
    import pfe_pkg::*;
#(
    parameter int NPIPE    = 2,
    parameter int ADDR_W   = 39,
    parameter int STRIDE_W = 8,
    parameter int CNT_W    = 4,
    parameter int QDEPTH   = 4,
    parameter int STAT_W   = 16
) (
    input logic                clk,
    input logic                reset,
    pfe_stride_engine_if.slave bus
);

    localparam int OPW = ADDR_W + STRIDE_W + CNT_W + 1;
    localparam int PW  = (NPIPE > 1) ? $clog2(NPIPE) : 1;

    pfe_state_e          state_q;
    pfe_state_e          state_d;
    logic                q_empty;
    logic                q_full;
    logic                q_pop;
    logic [OPW-1:0]      q_din;
    logic [OPW-1:0]      q_dout;
    logic [ADDR_W-1:0]   h_laddr;
    logic [STRIDE_W-1:0] h_stride;
    logic [CNT_W-1:0]    h_count;
    logic                h_l2;

    logic [ADDR_W-1:0]   cur_q;
    logic [CNT_W-1:0]    rem_q;
    logic                lvl_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [PW-1:0]       ptr_q [2];
    logic [PW-1:0]       tgt;
    logic [PW-1:0]       ptr_nxt;
    logic [ADDR_W-1:0]   stride_ext;

    logic load;
    logic zdrop;
    logic issue;
    logic consume;
    logic dup;
    logic slot_free;

    logic [NPIPE-1:0]    dc_vld_q;
    logic [NPIPE-1:0]    l2_vld_q;
    logic [ADDR_W-1:0]   dc_addr_q [NPIPE];
    logic [ADDR_W-1:0]   l2_addr_q [NPIPE];

    logic [STAT_W-1:0]       issued_q;
    logic [STAT_W-1:0]       dropped_q;
    logic [NPIPE*STAT_W-1:0] dcin_q;
    logic [NPIPE*STAT_W-1:0] l2in_q;
    logic [STAT_W-1:0]       dcstats_q;
    logic [STAT_W-1:0]       l2stats_q;
    logic [31:0]             dc_sum;
    logic [31:0]             l2_sum;

    assign q_din = {bus.pfgtopfe_op_laddr, bus.pfgtopfe_op_stride,
                    bus.pfgtopfe_op_count, bus.pfgtopfe_op_l2};
    assign {h_laddr, h_stride, h_count, h_l2} = q_dout;

    pfe_opq #(
        .W     (OPW),
        .DEPTH (QDEPTH)
    ) u_opq (
        .clk   (clk),
        .reset (reset),
        .push  (bus.pfgtopfe_op_valid),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full)
    );

    assign bus.pfgtopfe_op_retry = q_full;

    assign tgt        = ptr_q[lvl_q];
    assign ptr_nxt    = (tgt == PW'(NPIPE-1)) ? '0 : tgt + PW'(1);
    assign stride_ext = {{(ADDR_W-STRIDE_W){stride_q[STRIDE_W-1]}},
                         stride_q};
    assign slot_free  = lvl_q ?
        (!l2_vld_q[tgt] || !bus.pftol2_req_retry[tgt]) :
        (!dc_vld_q[tgt] || !bus.pftodc_req_retry[tgt]);

`ifdef PFE_DEDUP_EN
    logic [ADDR_W-1:0] last_q [2];
    logic [1:0]        last_vld_q;

    assign dup = last_vld_q[lvl_q] && (last_q[lvl_q] == cur_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_vld_q <= '0;
            last_q     <= '{default: '0};
        end else if (load) begin
            last_vld_q <= '0;
        end else if (issue) begin
            last_vld_q[lvl_q] <= 1'b1;
            last_q[lvl_q]     <= cur_q;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= PFE_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PFE_IDLE:  if (load) state_d = PFE_ISSUE;
            PFE_ISSUE: if (consume && rem_q == CNT_W'(1))
                           state_d = PFE_IDLE;
            default:   state_d = PFE_IDLE;
        endcase
    end

    // A duplicate line is consumed without needing a free slot.
    always_comb begin
        q_pop   = 1'b0;
        load    = 1'b0;
        zdrop   = 1'b0;
        issue   = 1'b0;
        consume = 1'b0;
        unique case (state_q)
            PFE_IDLE: begin
                q_pop = !q_empty;
                load  = !q_empty && (h_count != '0);
                zdrop = !q_empty && (h_count == '0);
            end
            PFE_ISSUE: begin
                issue   = slot_free && !dup;
                consume = issue || dup;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q    <= '0;
            rem_q    <= '0;
            lvl_q    <= 1'b0;
            stride_q <= '0;
            ptr_q    <= '{default: '0};
        end else if (load) begin
            cur_q    <= h_laddr;
            rem_q    <= h_count;
            lvl_q    <= h_l2;
            stride_q <= h_stride;
        end else if (consume) begin
            cur_q <= cur_q + stride_ext;
            rem_q <= rem_q - CNT_W'(1);
            if (issue) ptr_q[lvl_q] <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_vld_q <= '0;
            l2_vld_q <= '0;
            for (int i = 0; i < NPIPE; i++) begin
                dc_addr_q[i] <= '0;
                l2_addr_q[i] <= '0;
            end
        end else begin
            dc_vld_q <= dc_vld_q & bus.pftodc_req_retry;
            l2_vld_q <= l2_vld_q & bus.pftol2_req_retry;
            if (issue && lvl_q) begin
                l2_vld_q[tgt]  <= 1'b1;
                l2_addr_q[tgt] <= cur_q;
            end else if (issue) begin
                dc_vld_q[tgt]  <= 1'b1;
                dc_addr_q[tgt] <= cur_q;
            end
        end
    end

    for (genvar i = 0; i < NPIPE; i++) begin : g_flat
        assign bus.pftodc_req_laddr[i*ADDR_W +: ADDR_W] = dc_addr_q[i];
        assign bus.pftol2_req_laddr[i*ADDR_W +: ADDR_W] = l2_addr_q[i];
    end

    assign bus.pftodc_req_valid = dc_vld_q;
    assign bus.pftol2_req_valid = l2_vld_q;

    always_comb begin
        dc_sum = '0;
        l2_sum = '0;
        for (int i = 0; i < NPIPE; i++) begin
            dc_sum = sat_add(dc_sum,
                32'(dcin_q[i*STAT_W +: STAT_W]), STAT_W);
            l2_sum = sat_add(l2_sum,
                32'(l2in_q[i*STAT_W +: STAT_W]), STAT_W);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_q  <= '0;
            dropped_q <= '0;
            dcin_q    <= '0;
            l2in_q    <= '0;
            dcstats_q <= '0;
            l2stats_q <= '0;
        end else begin
            issued_q  <= STAT_W'(sat_add(32'(issued_q),
                             32'(issue), STAT_W));
            dropped_q <= STAT_W'(sat_add(32'(dropped_q),
                             32'(zdrop || (consume && !issue)),
                             STAT_W));
            dcin_q    <= bus.pf_dcstats_in;
            l2in_q    <= bus.pf_l2stats_in;
            dcstats_q <= STAT_W'(dc_sum);
            l2stats_q <= STAT_W'(l2_sum);
        end
    end

    assign bus.pf_issued  = issued_q;
    assign bus.pf_dropped = dropped_q;
    assign bus.pf_dcstats = dcstats_q;
    assign bus.pf_l2stats = l2stats_q;

endmodule
